// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock, shift-add multiply and
// restoring divide on a shared 64-bit accumulator, with a start/busy/done handshake.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // state    | meaning
  // S_IDLE   | waiting for start, operands captured on start
  // S_MUL    | one shift-add step per clock
  // S_DIV    | one restoring-divide step per clock
  // S_FINISH | sign-correct, register result, pulse done
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               special_q, special_d;
  logic [WIDTH-1:0]   special_val_q, special_val_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_by_zero, div_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed, rem_signed, fin_val;

  always_comb begin
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_signed && op_a[WIDTH-1];
    b_neg       = b_signed && op_b[WIDTH-1];
    a_mag       = a_neg ? -op_a : op_a;
    b_mag       = b_neg ? -op_b : op_b;
    div_by_zero = (op_b == '0);
    div_ovf     = !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (op_b == {WIDTH{1'b1}});

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Shifted partial remainder can exceed WIDTH bits, but the difference never does.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_diff = rem_sh[WIDTH-1:0] - b_q;

    prod_signed = neg_q ? -acc_q : acc_q;
    quo_signed  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_signed  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (special_q)          fin_val = special_val_q;
    else if (f3_q == 3'b000) fin_val = prod_signed[WIDTH-1:0];
    else if (!f3_q[2])       fin_val = prod_signed[2*WIDTH-1:WIDTH];
    else if (!f3_q[1])       fin_val = quo_signed;
    else                     fin_val = rem_signed;
  end

  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    b_d           = b_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    neg_d         = neg_q;
    rem_neg_d     = rem_neg_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    result_d      = result_q;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d          = funct3;
          b_d           = b_mag;
          acc_d         = {{WIDTH{1'b0}}, a_mag};
          neg_d         = a_neg ^ b_neg;
          rem_neg_d     = a_neg;
          cnt_d         = '0;
          special_d     = 1'b0;
          special_val_d = '0;
          if (!funct3[2]) begin
            state_d = S_MUL;
          end else if (div_by_zero) begin
            special_d     = 1'b1;
            special_val_d = funct3[1] ? op_a : {WIDTH{1'b1}};
            state_d       = S_FINISH;
          end else if (div_ovf) begin
            special_d     = 1'b1;
            special_val_d = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            state_d       = S_FINISH;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FINISH;
      end
      S_DIV: begin
        acc_d = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = S_FINISH;
      end
      S_FINISH: begin
        result_d = fin_val;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      f3_q          <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      neg_q         <= neg_d;
      rem_neg_q     <= rem_neg_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
